// File: rtl/window_buffer_7x7_pkg.sv
// Shared pixel and window dimensions for the 7x7 sliding-window builder.
package window_buffer_7x7_pkg;
    localparam int PIXEL_W = 8;
    localparam int WIN     = 7;

    typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/window_row_shift7.sv
// One window row: a 7-deep enable-gated pixel shift register with synchronous clear.
// taps[0] is the oldest (leftmost) pixel, taps[WIN-1] the newest.
module window_row_shift7
    import window_buffer_7x7_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  pixel_t               din,
    output pixel_t [WIN-1:0]     taps
);

    always_ff @(posedge clk) begin
        if (clr) begin
            taps <= '0;
        end else if (en) begin
            taps <= {din, taps[WIN-1:1]};
        end
    end

endmodule

// File: rtl/window_buffer_7x7.sv
// 7x7 sliding window fed one vertical column per valid cycle; flags in-row windows
// and pulses progress_done_o on the frame's final window.
module window_buffer_7x7
    import window_buffer_7x7_pkg::*;
#(
    parameter int COLS = 9,
    parameter int ROWS = 9
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   done_i,
    input  pixel_t S1_i,
    input  pixel_t S2_i,
    input  pixel_t S3_i,
    input  pixel_t S4_i,
    input  pixel_t S5_i,
    input  pixel_t S6_i,
    input  pixel_t S7_i,
    output pixel_t S1_o,  output pixel_t S2_o,  output pixel_t S3_o,  output pixel_t S4_o,
    output pixel_t S5_o,  output pixel_t S6_o,  output pixel_t S7_o,  output pixel_t S8_o,
    output pixel_t S9_o,  output pixel_t S10_o, output pixel_t S11_o, output pixel_t S12_o,
    output pixel_t S13_o, output pixel_t S14_o, output pixel_t S15_o, output pixel_t S16_o,
    output pixel_t S17_o, output pixel_t S18_o, output pixel_t S19_o, output pixel_t S20_o,
    output pixel_t S21_o, output pixel_t S22_o, output pixel_t S23_o, output pixel_t S24_o,
    output pixel_t S25_o, output pixel_t S26_o, output pixel_t S27_o, output pixel_t S28_o,
    output pixel_t S29_o, output pixel_t S30_o, output pixel_t S31_o, output pixel_t S32_o,
    output pixel_t S33_o, output pixel_t S34_o, output pixel_t S35_o, output pixel_t S36_o,
    output pixel_t S37_o, output pixel_t S38_o, output pixel_t S39_o, output pixel_t S40_o,
    output pixel_t S41_o, output pixel_t S42_o, output pixel_t S43_o, output pixel_t S44_o,
    output pixel_t S45_o, output pixel_t S46_o, output pixel_t S47_o, output pixel_t S48_o,
    output pixel_t S49_o,
    output logic   done_o,
    output logic   progress_done_o
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = ((ROWS - 6) > 1) ? $clog2(ROWS - 6) : 1;

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             col_last;
    logic             row_last;

    pixel_t           col_in [WIN];
    pixel_t [WIN-1:0] win    [WIN];

    assign col_in[0] = S1_i;
    assign col_in[1] = S2_i;
    assign col_in[2] = S3_i;
    assign col_in[3] = S4_i;
    assign col_in[4] = S5_i;
    assign col_in[5] = S6_i;
    assign col_in[6] = S7_i;

    for (genvar r = 0; r < WIN; r++) begin : g_row
        window_row_shift7 u_row (
            .clk  (clk),
            .clr  (rst),
            .en   (done_i),
            .din  (col_in[r]),
            .taps (win[r])
        );
    end

    assign col_last = (col_cnt == COL_W'(COLS - 1));
    assign row_last = (row_cnt == ROW_W'(ROWS - 7));

    // A window is complete once the 7th column of the current row has been shifted in.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end else if (done_i) begin
            done_o          <= (col_cnt >= COL_W'(WIN - 1));
            progress_done_o <= col_last && row_last;
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
        end else begin
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end
    end

    assign S1_o  = win[0][0]; assign S2_o  = win[0][1]; assign S3_o  = win[0][2];
    assign S4_o  = win[0][3]; assign S5_o  = win[0][4]; assign S6_o  = win[0][5];
    assign S7_o  = win[0][6];
    assign S8_o  = win[1][0]; assign S9_o  = win[1][1]; assign S10_o = win[1][2];
    assign S11_o = win[1][3]; assign S12_o = win[1][4]; assign S13_o = win[1][5];
    assign S14_o = win[1][6];
    assign S15_o = win[2][0]; assign S16_o = win[2][1]; assign S17_o = win[2][2];
    assign S18_o = win[2][3]; assign S19_o = win[2][4]; assign S20_o = win[2][5];
    assign S21_o = win[2][6];
    assign S22_o = win[3][0]; assign S23_o = win[3][1]; assign S24_o = win[3][2];
    assign S25_o = win[3][3]; assign S26_o = win[3][4]; assign S27_o = win[3][5];
    assign S28_o = win[3][6];
    assign S29_o = win[4][0]; assign S30_o = win[4][1]; assign S31_o = win[4][2];
    assign S32_o = win[4][3]; assign S33_o = win[4][4]; assign S34_o = win[4][5];
    assign S35_o = win[4][6];
    assign S36_o = win[5][0]; assign S37_o = win[5][1]; assign S38_o = win[5][2];
    assign S39_o = win[5][3]; assign S40_o = win[5][4]; assign S41_o = win[5][5];
    assign S42_o = win[5][6];
    assign S43_o = win[6][0]; assign S44_o = win[6][1]; assign S45_o = win[6][2];
    assign S46_o = win[6][3]; assign S47_o = win[6][4]; assign S48_o = win[6][5];
    assign S49_o = win[6][6];

endmodule

// File: tb/tb_window_buffer_7x7.sv
// Directed bench for window_buffer_7x7 (COLS=9, ROWS=9): table-driven frame stream
// plus hand-written stall and mid-frame reset sequences.
module tb_window_buffer_7x7;

    // Row r of a column carries value v + ROW_OFS*r so row-mapping errors show up.
    localparam int ROW_OFS = 30;

    typedef struct {
        logic rst;
        logic dv;
        int   val;
        logic exp_done;
        logic exp_prog;
        int   win_mode;   // 0: no window check, 1: all zero, 2: window ending at exp_newest
        int   exp_newest;
    } vec_t;

    logic clk;
    logic rst;
    logic done_i;
    logic [6:0][7:0]  s_in;
    logic [48:0][7:0] s_out;
    logic done_o;
    logic progress_done_o;

    int n_checks;
    int n_errors;

    vec_t vecs [$];

    window_buffer_7x7 #(.COLS(9), .ROWS(9)) dut (
        .clk(clk), .rst(rst), .done_i(done_i),
        .S1_i(s_in[0]), .S2_i(s_in[1]), .S3_i(s_in[2]), .S4_i(s_in[3]),
        .S5_i(s_in[4]), .S6_i(s_in[5]), .S7_i(s_in[6]),
        .S1_o(s_out[0]),   .S2_o(s_out[1]),   .S3_o(s_out[2]),   .S4_o(s_out[3]),
        .S5_o(s_out[4]),   .S6_o(s_out[5]),   .S7_o(s_out[6]),   .S8_o(s_out[7]),
        .S9_o(s_out[8]),   .S10_o(s_out[9]),  .S11_o(s_out[10]), .S12_o(s_out[11]),
        .S13_o(s_out[12]), .S14_o(s_out[13]), .S15_o(s_out[14]), .S16_o(s_out[15]),
        .S17_o(s_out[16]), .S18_o(s_out[17]), .S19_o(s_out[18]), .S20_o(s_out[19]),
        .S21_o(s_out[20]), .S22_o(s_out[21]), .S23_o(s_out[22]), .S24_o(s_out[23]),
        .S25_o(s_out[24]), .S26_o(s_out[25]), .S27_o(s_out[26]), .S28_o(s_out[27]),
        .S29_o(s_out[28]), .S30_o(s_out[29]), .S31_o(s_out[30]), .S32_o(s_out[31]),
        .S33_o(s_out[32]), .S34_o(s_out[33]), .S35_o(s_out[34]), .S36_o(s_out[35]),
        .S37_o(s_out[36]), .S38_o(s_out[37]), .S39_o(s_out[38]), .S40_o(s_out[39]),
        .S41_o(s_out[40]), .S42_o(s_out[41]), .S43_o(s_out[42]), .S44_o(s_out[43]),
        .S45_o(s_out[44]), .S46_o(s_out[45]), .S47_o(s_out[46]), .S48_o(s_out[47]),
        .S49_o(s_out[48]),
        .done_o(done_o), .progress_done_o(progress_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic r, input logic d, input int v);
        rst    = r;
        done_i = d;
        for (int k = 0; k < 7; k++) s_in[k] = 8'(v + ROW_OFS * k);
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_window(input string name, input bit zero, input int newest);
        logic [7:0] exp;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                exp = zero ? 8'd0 : 8'(newest - 6 + c + ROW_OFS * r);
                n_checks++;
                if (s_out[r*7+c] !== exp) begin
                    n_errors++;
                    $display("[TB] FAIL %s S%0d_o: got %0d expected %0d",
                             name, r*7+c+1, s_out[r*7+c], exp);
                end
            end
        end
    endtask

    task automatic check_output(input string name, input vec_t v);
        check_bit({name, " done_o"}, done_o, v.exp_done);
        check_bit({name, " progress_done_o"}, progress_done_o, v.exp_prog);
        if (v.win_mode == 1) check_window(name, 1'b1, 0);
        if (v.win_mode == 2) check_window(name, 1'b0, v.exp_newest);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        apply_stimulus(v.rst, v.dv, v.val);
        check_output(name, v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        done_i   = 1'b0;
        s_in     = '0;

        // Reset with nonzero inputs, then a full 27-column frame and one extra column.
        vecs.push_back('{1'b1, 1'b1, 99, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{1'b1, 1'b1, 99, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 2,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 3,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 4,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 5,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 6,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 7,  1'b1, 1'b0, 2, 7});
        vecs.push_back('{1'b0, 1'b1, 8,  1'b1, 1'b0, 2, 8});
        vecs.push_back('{1'b0, 1'b1, 9,  1'b1, 1'b0, 2, 9});
        vecs.push_back('{1'b0, 1'b1, 10, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 11, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 12, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 13, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 14, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 15, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 16, 1'b1, 1'b0, 2, 16});
        vecs.push_back('{1'b0, 1'b1, 17, 1'b1, 1'b0, 2, 17});
        vecs.push_back('{1'b0, 1'b1, 18, 1'b1, 1'b0, 2, 18});
        vecs.push_back('{1'b0, 1'b1, 19, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 20, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 21, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 22, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 23, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 24, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 25, 1'b1, 1'b0, 2, 25});
        vecs.push_back('{1'b0, 1'b1, 26, 1'b1, 1'b0, 2, 26});
        vecs.push_back('{1'b0, 1'b1, 27, 1'b1, 1'b1, 2, 27});
        vecs.push_back('{1'b0, 1'b1, 28, 1'b0, 1'b0, 0, 0});

        $display("[TB] frame stream: %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("frame[%0d]", i), vecs[i]);
        end

        // Stall for 3 cycles after column 8; counters and window must hold.
        $display("[TB] stall sequence");
        apply_stimulus(1'b1, 1'b0, 0);
        for (int v = 1; v <= 8; v++) apply_stimulus(1'b0, 1'b1, v);
        check_output("stall col8", '{1'b0, 1'b1, 8, 1'b1, 1'b0, 2, 8});
        for (int k = 0; k < 3; k++) begin
            run_vec($sformatf("stall idle%0d", k), '{1'b0, 1'b0, 200, 1'b0, 1'b0, 2, 8});
        end
        run_vec("stall resume col9", '{1'b0, 1'b1, 9, 1'b1, 1'b0, 2, 9});
        run_vec("stall col10", '{1'b0, 1'b1, 10, 1'b0, 1'b0, 0, 0});

        // Reset after column 12 discards the partial frame.
        $display("[TB] mid-frame reset sequence");
        apply_stimulus(1'b1, 1'b0, 0);
        for (int v = 1; v <= 12; v++) apply_stimulus(1'b0, 1'b1, v);
        run_vec("midrst reset", '{1'b1, 1'b1, 50, 1'b0, 1'b0, 1, 0});
        for (int v = 1; v <= 6; v++) begin
            run_vec($sformatf("midrst col%0d", v), '{1'b0, 1'b1, v, 1'b0, 1'b0, 0, 0});
        end
        run_vec("midrst col7", '{1'b0, 1'b1, 7, 1'b1, 1'b0, 2, 7});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
